// File: rtl/led_breath_pkg.sv
// Shared definitions for LED blocks: phase encodings and counter widths.
package led_breath_pkg;

    typedef enum logic [1:0] {
        PHASE_UP      = 2'd0,
        PHASE_HOLD_HI = 2'd1,
        PHASE_DOWN    = 2'd2,
        PHASE_HOLD_LO = 2'd3
    } phase_e;

    localparam int HOLD_CNT_BITS = 16;

endpackage

// File: rtl/led_breath_if.sv
// Control/status bundle between the tick source, the breathing block and the LED pin.
interface led_breath_if #(
    parameter int PWM_BITS = 8
);
    logic                tick;
    logic                enable;
    logic                led_o;
    logic [PWM_BITS-1:0] level_o;
    logic [1:0]          phase_o;

    modport master (output tick, output enable, input led_o, input level_o, input phase_o);
    modport slave  (input tick, input enable, output led_o, output level_o, output phase_o);
endinterface

// File: rtl/led_pwm.sv
// Free-running PWM: duty is latched only at the period boundary so a mid-period
// level change never produces a runt pulse; clr blanks the output at once.
module led_pwm #(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic                pwm_o
);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
    localparam logic [PWM_BITS-1:0] CNT_ONE = PWM_BITS'(1);

    logic [PWM_BITS-1:0] r_cnt;
    logic [PWM_BITS-1:0] r_duty;
    logic                r_pwm;
    logic                w_lit;

    assign w_lit = (r_cnt < r_duty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_duty <= '0;
            r_pwm  <= 1'b0;
        end else begin
            r_cnt <= r_cnt + CNT_ONE;
            if (clr) begin
                r_duty <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_duty <= duty_i;
            end
            r_pwm <= w_lit & ~clr;
        end
    end

    assign pwm_o = r_pwm;
endmodule

// File: rtl/led_breath.sv
// Breathing LED: ramp up, hold, ramp down, hold; one step per enabled tick,
// brightness rendered by led_pwm and polarity applied at the pin.
module led_breath
    import led_breath_pkg::*;
#(
    parameter int PWM_BITS       = 8,
    parameter int HOLD_TICKS     = 16,
    parameter int LED_ACTIVE_LOW = 1
) (
    input logic        clk,
    input logic        rst_n,
    led_breath_if.slave bus
);
    localparam logic [PWM_BITS-1:0]      LVL_ONE   = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0]      LVL_TOP   = {{(PWM_BITS-1){1'b1}}, 1'b0};
    localparam logic [HOLD_CNT_BITS-1:0] HOLD_LAST = HOLD_CNT_BITS'(HOLD_TICKS - 1);
    localparam logic [HOLD_CNT_BITS-1:0] HOLD_ONE  = HOLD_CNT_BITS'(1);
    localparam logic                     POL       = (LED_ACTIVE_LOW != 0);

    phase_e                   r_phase, w_phase_next;
    logic [PWM_BITS-1:0]      r_level, w_level_next;
    logic [HOLD_CNT_BITS-1:0] r_hold_cnt, w_hold_next;
    logic                     w_pwm;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase    <= PHASE_HOLD_LO;
            r_level    <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_phase    <= w_phase_next;
            r_level    <= w_level_next;
            r_hold_cnt <= w_hold_next;
        end
    end

    // Ramps end one step early on purpose, so level saturates at 0/MAX without wrapping.
    always_comb begin
        w_phase_next = r_phase;
        w_level_next = r_level;
        w_hold_next  = r_hold_cnt;
        if (!bus.enable) begin
            w_phase_next = PHASE_HOLD_LO;
            w_level_next = '0;
            w_hold_next  = '0;
        end else if (bus.tick) begin
            case (r_phase)
                PHASE_UP: begin
                    w_level_next = r_level + LVL_ONE;
                    if (r_level == LVL_TOP) begin
                        w_phase_next = PHASE_HOLD_HI;
                        w_hold_next  = '0;
                    end
                end
                PHASE_HOLD_HI: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_phase_next = PHASE_DOWN;
                        w_hold_next  = '0;
                    end else begin
                        w_hold_next = r_hold_cnt + HOLD_ONE;
                    end
                end
                PHASE_DOWN: begin
                    w_level_next = r_level - LVL_ONE;
                    if (r_level == LVL_ONE) begin
                        w_phase_next = PHASE_HOLD_LO;
                        w_hold_next  = '0;
                    end
                end
                PHASE_HOLD_LO: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        w_phase_next = PHASE_UP;
                        w_hold_next  = '0;
                    end else begin
                        w_hold_next = r_hold_cnt + HOLD_ONE;
                    end
                end
                default: begin
                    w_phase_next = PHASE_HOLD_LO;
                end
            endcase
        end
    end

    led_pwm #(
        .PWM_BITS (PWM_BITS)
    ) u_pwm (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (~bus.enable),
        .duty_i (r_level),
        .pwm_o  (w_pwm)
    );

    assign bus.led_o   = w_pwm ^ POL;
    assign bus.level_o = r_level;
    assign bus.phase_o = r_phase;
endmodule
